// File: rtl/halve_tokens_pkg.sv
// Shared constants and types for the halve_tokens block.
// Holds default credit depth, count width and the credit-count type.
package halve_tokens_pkg;

    localparam int MAX_CREDITS_DEFAULT = 200;
    localparam int CW_DEFAULT          = 8;

    typedef logic [CW_DEFAULT-1:0] credit_t;

endpackage

// File: rtl/halve_tokens_if.sv
// Token stream bundle: a/flush in, b_ready/b downstream handshake.
// master drives a, flush, b_ready; slave drives b.
interface halve_tokens_if;

    logic a;
    logic flush;
    logic b_ready;
    logic b;

    modport master (
        output a,
        output flush,
        output b_ready,
        input  b
    );

    modport slave (
        input  a,
        input  flush,
        input  b_ready,
        output b
    );

endinterface

// File: rtl/halve_tokens_counter.sv
// token_credit_counter: saturating up/down count with sticky overflow.
// Ports: clk, rst, inc, dec -> count[CW-1:0], overflow.
module token_credit_counter
    import halve_tokens_pkg::*;
#(
    parameter int MAX_CREDITS = MAX_CREDITS_DEFAULT,
    parameter int CW          = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam logic [CW:0] MAX_W = (CW+1)'(MAX_CREDITS);

    logic [CW:0] sum;
    logic        over;

    // One extra bit so count+1 at the cap is visible before clamping.
    assign sum  = {1'b0, count} + {{CW{1'b0}}, inc} - {{CW{1'b0}}, dec};
    assign over = (sum > MAX_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            count <= over ? MAX_W[CW-1:0] : sum[CW-1:0];
            if (over)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/halve_tokens.sv
// halve_tokens: emits one output token per two input tokens, queued by credits.
// Ports: clk, rst, bus (slave: a, flush, b_ready -> b), half, credits, overflow.
module halve_tokens
    import halve_tokens_pkg::*;
#(
    parameter int MAX_CREDITS = MAX_CREDITS_DEFAULT,
    parameter int CW          = CW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    halve_tokens_if.slave  bus,
    output logic           half,
    output logic [CW-1:0]  credits,
    output logic           overflow
);

    logic [1:0] n;
    logic       pair;
    logic       half_next;

    assign n    = {1'b0, half} + {1'b0, bus.a};
    assign pair = (n == 2'd2) | (bus.flush & (n == 2'd1));

    assign half_next = ~bus.flush & (n == 2'd1);

    // A completing token bypasses the queue when no credits are waiting.
    assign bus.b = bus.b_ready & ((credits != '0) | pair) & ~rst;

    always_ff @(posedge clk) begin
        if (rst)
            half <= 1'b0;
        else
            half <= half_next;
    end

    token_credit_counter #(
        .MAX_CREDITS (MAX_CREDITS),
        .CW          (CW)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (pair),
        .dec      (bus.b),
        .count    (credits),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_halve_tokens.sv
// Self-checking bench for halve_tokens: directed scenarios plus random traffic.
// Reference model tracks pending half, queued credits and overflow as integers.
module tb_halve_tokens;
    import halve_tokens_pkg::*;

    localparam int MAXC = MAX_CREDITS_DEFAULT;

    logic    clk = 1'b0;
    logic    rst;
    logic    half;
    credit_t credits;
    logic    overflow;

    halve_tokens_if bus ();

    halve_tokens #(
        .MAX_CREDITS (MAXC),
        .CW          (CW_DEFAULT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .half     (half),
        .credits  (credits),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int m_half = 0;
    int m_cred = 0;
    int m_ovf  = 0;
    int last_b = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: check b mid-cycle, then check registered state after the edge.
    task automatic cyc(input int ia, input int ifl, input int ir, input int irst);
        int tokens;
        int done;
        int eb;
        @(negedge clk);
        bus.a       = ia[0];
        bus.flush   = ifl[0];
        bus.b_ready = ir[0];
        rst         = irst[0];
        #1;
        tokens = m_half + ia;
        done   = (tokens == 2 || (ifl != 0 && tokens == 1)) ? 1 : 0;
        eb     = (irst == 0 && ir != 0 && (m_cred > 0 || done != 0)) ? 1 : 0;
        last_b = int'(bus.b);
        chk("b", last_b, eb);
        @(posedge clk);
        if (irst != 0) begin
            m_half = 0;
            m_cred = 0;
            m_ovf  = 0;
        end else begin
            m_cred = m_cred + done - eb;
            if (m_cred > MAXC) begin
                m_cred = MAXC;
                m_ovf  = 1;
            end
            m_half = (ifl == 0 && tokens == 1) ? 1 : 0;
        end
        #1;
        chk("half", int'(half), m_half);
        chk("credits", int'(credits), m_cred);
        chk("overflow", int'(overflow), m_ovf);
    endtask

    initial begin
        logic [3:0] bv;
        logic [3:0] hv;
        int         cnt;
        bus.a = 0; bus.flush = 0; bus.b_ready = 0; rst = 1;

        cyc(1, 0, 1, 1);
        cyc(0, 0, 1, 1);

        // 1111 in with ready: b 0101, half 1010, credits stay 0.
        bv = '0; hv = '0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 1, 0);
            bv = {bv[2:0], last_b[0]};
            hv = {hv[2:0], half};
            chk("credits_bypass", int'(credits), 0);
        end
        chk("b_pattern", int'(bv), 4'b0101);
        chk("half_pattern", int'(hv), 4'b1010);

        // Flush rounds a lone token up.
        cyc(1, 0, 1, 0);
        cyc(0, 1, 1, 0);
        chk("flush_b", last_b, 1);
        chk("flush_half", int'(half), 0);
        cyc(0, 1, 1, 0);
        chk("flush_empty_b", last_b, 0);

        // Fill to the cap, then overflow, then drain.
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 400; i++) cyc(1, 0, 0, 0);
        chk("fill_credits", int'(credits), MAXC);
        chk("fill_ovf", int'(overflow), 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("ovf_credits", int'(credits), MAXC);
        chk("ovf_set", int'(overflow), 1);
        cnt = 0;
        for (int i = 0; i < MAXC; i++) begin
            cyc(0, 0, 1, 0);
            cnt += last_b;
        end
        chk("drain_count", cnt, MAXC);
        chk("drain_credits", int'(credits), 0);
        chk("drain_ovf", int'(overflow), 1);

        // At the cap with ready: completing tokens pass, credits hold.
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 401; i++) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        chk("full_b0", last_b, 1);
        chk("full_cred0", int'(credits), MAXC);
        cyc(1, 1, 1, 0);
        chk("full_b1", last_b, 1);
        chk("full_cred1", int'(credits), MAXC);
        chk("full_ovf", int'(overflow), 0);

        // Mid-stream reset discards credits and the half token.
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 11; i++) cyc(1, 0, 0, 0);
        chk("pre_rst_credits", int'(credits), 5);
        chk("pre_rst_half", int'(half), 1);
        cyc(1, 1, 1, 1);
        chk("rst_b", last_b, 0);
        chk("rst_credits", int'(credits), 0);
        chk("rst_half", int'(half), 0);
        cyc(1, 0, 1, 0);
        chk("fresh_b", last_b, 0);

        // Random traffic across several ready/flush biases.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 1500; i++) begin
                cyc(int'($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 3) < p),
                    int'($urandom_range(0, 499) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
